// File: rtl/io_interface_arbiter_if.sv
// ============================================================================
// Module   : io_interface_arbiter_if
// Brief    : Channel-side and external-side IO handshake bundle for the arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface io_interface_arbiter_if #(
    parameter int CH_NUM = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [CH_NUM-1:0]        in_taskValid;
    logic [CH_NUM*ADDR_W-1:0] in_address;
    logic [CH_NUM-1:0]        in_rwCtrl;
    logic [CH_NUM*2-1:0]      in_widthCtr;
    logic [CH_NUM*DATA_W-1:0] in_writeBus;
    logic [CH_NUM-1:0]        in_taskReady;
    logic [CH_NUM-1:0]        in_taskError;
    logic [CH_NUM*DATA_W-1:0] in_readBus;

    logic                     out_taskValid;
    logic [ADDR_W-1:0]        out_address;
    logic                     out_rwCtrl;
    logic [1:0]               out_widthCtr;
    logic [DATA_W-1:0]        out_writeBus;
    logic                     out_taskReady;
    logic                     out_taskError;
    logic [DATA_W-1:0]        out_readBus;

    // Arbiter view
    modport slave (
        input  in_taskValid, in_address, in_rwCtrl, in_widthCtr, in_writeBus,
        output in_taskReady, in_taskError, in_readBus,
        output out_taskValid, out_address, out_rwCtrl, out_widthCtr, out_writeBus,
        input  out_taskReady, out_taskError, out_readBus
    );

    // Requesters plus downstream port view
    modport master (
        output in_taskValid, in_address, in_rwCtrl, in_widthCtr, in_writeBus,
        input  in_taskReady, in_taskError, in_readBus,
        input  out_taskValid, out_address, out_rwCtrl, out_widthCtr, out_writeBus,
        output out_taskReady, out_taskError, out_readBus
    );
endinterface

`default_nettype wire

// File: rtl/io_interface_arbiter.sv
// ============================================================================
// Module   : io_interface_arbiter
// Brief    : N-channel IO arbiter, absolute-priority channel plus fixed/RR
//            arbitration, grant held per transaction, timeout watchdog
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module io_interface_arbiter #(
    parameter int CH_NUM  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PRIO_CH = 0,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 255
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    io_interface_arbiter_if.slave bus,
    output logic [CH_NUM-1:0]     grant,
    output logic                  timeout_err
);

    localparam int c_IDX_W = $clog2(CH_NUM);
    localparam int c_CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? c_CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [c_IDX_W-1:0] c_PRIO    = c_IDX_W'(PRIO_CH);
    localparam logic [c_IDX_W-1:0] c_LAST    = c_IDX_W'(CH_NUM - 1);

    generate
        if (PRIO_CH < 0 || PRIO_CH >= CH_NUM) begin : g_bad_prio
            $error("io_interface_arbiter: PRIO_CH out of range 0..CH_NUM-1");
        end
        if (CH_NUM < 2 || CH_NUM > 8) begin : g_bad_chnum
            $error("io_interface_arbiter: CH_NUM must be 2..8");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [CH_NUM-1:0]    r_grant, w_grant_nxt;
    logic [c_IDX_W-1:0]   r_gidx,  w_gidx_nxt;
    logic [c_IDX_W-1:0]   r_ptr,   w_ptr_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic                 w_pick_vld;
    logic [c_IDX_W-1:0]   w_pick;
    logic                 w_busy;
    logic                 w_own_vld;
    logic                 w_timeout;

    // Winner selection: priority channel first, then scan from the pointer (RR) or from 0
    always_comb begin
        int j;
        j          = 0;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        if (bus.in_taskValid[PRIO_CH]) begin
            w_pick_vld = 1'b1;
            w_pick     = c_PRIO;
        end else begin
            for (int k = 0; k < CH_NUM; k++) begin
                j = (RR_MODE != 0) ? int'(r_ptr) + k : k;
                if (j >= CH_NUM) j = j - CH_NUM;
                if (!w_pick_vld && j != PRIO_CH && bus.in_taskValid[j]) begin
                    w_pick_vld = 1'b1;
                    w_pick     = c_IDX_W'(j);
                end
            end
        end
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_own_vld = bus.in_taskValid[r_gidx];
    // A downstream completion in the expiry cycle takes precedence over the abort
    assign w_timeout = (TIMEOUT != 0) && w_busy && !bus.out_taskReady && w_own_vld
                       && (r_cnt == c_TO_LAST);

    always_comb begin
        bus.out_taskValid = 1'b0;
        bus.out_address   = '0;
        bus.out_rwCtrl    = 1'b0;
        bus.out_widthCtr  = '0;
        bus.out_writeBus  = '0;
        bus.in_taskReady  = '0;
        bus.in_taskError  = '0;
        bus.in_readBus    = '0;
        if (w_busy) begin
            bus.out_taskValid = w_own_vld && !w_timeout;
            bus.out_address   = bus.in_address[r_gidx*ADDR_W +: ADDR_W];
            bus.out_rwCtrl    = bus.in_rwCtrl[r_gidx];
            bus.out_widthCtr  = bus.in_widthCtr[r_gidx*2 +: 2];
            bus.out_writeBus  = bus.in_writeBus[r_gidx*DATA_W +: DATA_W];
            bus.in_taskReady[r_gidx] = bus.out_taskReady || w_timeout;
            bus.in_taskError[r_gidx] = bus.out_taskError || w_timeout;
            bus.in_readBus[r_gidx*DATA_W +: DATA_W] = w_timeout ? '0 : bus.out_readBus;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_ptr_nxt   = r_ptr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_pick_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_gidx_nxt  = w_pick;
                    w_grant_nxt = CH_NUM'(1) << w_pick;
                end
            end
            ST_BUSY: begin
                if (bus.out_taskReady) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                    if (r_gidx != c_PRIO) begin
                        w_ptr_nxt = (r_gidx == c_LAST) ? '0 : r_gidx + c_IDX_W'(1);
                    end
                end else if (!w_own_vld || w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (TIMEOUT != 0) begin
                    w_cnt_nxt = r_cnt + c_CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_ptr   <= w_ptr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign grant       = r_grant;
    assign timeout_err = w_timeout;

endmodule

`default_nettype wire

// File: tb/tb_io_interface_arbiter.sv
// ============================================================================
// Module   : tb_io_interface_arbiter
// Brief    : Self-checking bench for io_interface_arbiter (vectors + random)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_io_interface_arbiter;

    localparam int N    = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int PRIO = 0;
    localparam int RR   = 1;
    localparam int TO   = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] grant;
    logic         timeout_err;
    int           total = 0;
    int           bad = 0;

    always #5 clk = ~clk;

    io_interface_arbiter_if #(.CH_NUM(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    io_interface_arbiter #(
        .CH_NUM(N), .ADDR_W(AW), .DATA_W(DW),
        .PRIO_CH(PRIO), .RR_MODE(RR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .grant(grant), .timeout_err(timeout_err)
    );

    logic [AW-1:0] ch_addr [N];
    logic [DW-1:0] ch_wdat [N];
    logic          ch_rw   [N];
    logic [1:0]    ch_wid  [N];

    // Reference model: owner, pointer and busy-cycle count at transaction level
    bit m_busy;
    int m_owner, m_ptr, m_bc;

    typedef struct {
        logic [N-1:0]  req;
        int            win;
        int            lat;
        logic [DW-1:0] rd;
        bit            err;
    } vec_t;
    vec_t tbl [6];
    int   rr_seq [4];

    logic [N-1:0] gr, er, act;
    bit           gt;
    int           hang;

    task automatic chk(input string name, input logic [N*DW-1:0] act_v, input logic [N*DW-1:0] exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h @%0t", name, act_v, exp_v, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [N-1:0] v);
        int best, bestd, d;
        best = -1;
        bestd = N;
        if (v[PRIO]) return PRIO;
        for (int i = 0; i < N; i++) begin
            if (v[i] && i != PRIO) begin
                d = RR ? (i - m_ptr + N) % N : i;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0;
        m_owner = 0;
        m_ptr = 0;
        m_bc = 0;
    endtask

    task automatic randomize_fields();
        for (int i = 0; i < N; i++) begin
            ch_addr[i] = $urandom;
            ch_wdat[i] = $urandom;
            ch_rw[i]   = 1'($urandom_range(0, 1));
            ch_wid[i]  = 2'($urandom_range(0, 3));
        end
    endtask

    // One clock: drive at negedge, check against the model, advance the model, end after posedge
    task automatic step(input logic [N-1:0] v, input bit want_ready, input bit e, input logic [DW-1:0] rd,
                        output logic [N-1:0] got_rdy, output bit got_to, output logic [N-1:0] exp_rdy);
        logic [N-1:0]    eg, erd_r, ee;
        logic [N*DW-1:0] erd;
        bit              ev, tnow, r;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            bus.in_address[i*AW +: AW]  = ch_addr[i];
            bus.in_writeBus[i*DW +: DW] = ch_wdat[i];
            bus.in_rwCtrl[i]            = ch_rw[i];
            bus.in_widthCtr[i*2 +: 2]   = ch_wid[i];
        end
        bus.in_taskValid = v;
        r    = m_busy && v[m_owner] && want_ready;
        tnow = m_busy && !r && v[m_owner] && (TO != 0) && (m_bc + 1 == TO);
        ev   = m_busy && v[m_owner] && !tnow;
        eg = '0; erd_r = '0; ee = '0; erd = '0;
        if (m_busy) begin
            eg[m_owner]    = 1'b1;
            erd_r[m_owner] = r || tnow;
            ee[m_owner]    = e || tnow;
            erd[m_owner*DW +: DW] = tnow ? '0 : rd;
        end
        bus.out_taskReady = r;
        bus.out_taskError = e;
        bus.out_readBus   = rd;
        #1;
        chk("grant", grant, eg);
        chk("out_taskValid", bus.out_taskValid, ev);
        chk("in_taskReady", bus.in_taskReady, erd_r);
        chk("in_taskError", bus.in_taskError, ee);
        chk("in_readBus", bus.in_readBus, erd);
        chk("timeout_err", timeout_err, tnow);
        if (m_busy) begin
            chk("out_address", bus.out_address, ch_addr[m_owner]);
            chk("out_writeBus", bus.out_writeBus, ch_wdat[m_owner]);
            chk("out_rwCtrl", bus.out_rwCtrl, ch_rw[m_owner]);
            chk("out_widthCtr", bus.out_widthCtr, ch_wid[m_owner]);
        end
        got_rdy = bus.in_taskReady;
        got_to  = timeout_err;
        exp_rdy = erd_r;
        if (!m_busy) begin
            if (v != '0) begin
                m_busy = 1'b1;
                m_owner = pick(v);
                m_bc = 0;
            end
        end else if (r) begin
            m_busy = 1'b0;
            if (m_owner != PRIO) m_ptr = (m_owner + 1) % N;
        end else if (!v[m_owner] || tnow) begin
            m_busy = 1'b0;
        end else begin
            m_bc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_taskValid = '1;
        bus.out_taskReady = 1'b1;
        bus.out_taskError = 1'b1;
        bus.out_readBus = '1;
        #2;
        chk("rst_grant", grant, '0);
        chk("rst_out_taskValid", bus.out_taskValid, 1'b0);
        chk("rst_out_address", bus.out_address, '0);
        chk("rst_in_taskReady", bus.in_taskReady, '0);
        chk("rst_in_taskError", bus.in_taskError, '0);
        chk("rst_in_readBus", bus.in_readBus, '0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        @(negedge clk);
        bus.in_taskValid = '0;
        bus.out_taskReady = 1'b0;
        bus.out_taskError = 1'b0;
        bus.out_readBus = '0;
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench stuck");
    end

    initial begin
        bus.in_taskValid = '0; bus.in_address = '0; bus.in_rwCtrl = '0;
        bus.in_widthCtr = '0;  bus.in_writeBus = '0;
        bus.out_taskReady = 1'b0; bus.out_taskError = 1'b0; bus.out_readBus = '0;
        model_reset();
        randomize_fields();

        // Single transactions from reset (pointer = 0)
        tbl[0] = '{req: 4'b0100, win: 2, lat: 3, rd: 32'hDEADBEEF, err: 1'b0};
        tbl[1] = '{req: 4'b1110, win: 1, lat: 0, rd: 32'h12345678, err: 1'b0};
        tbl[2] = '{req: 4'b1111, win: 0, lat: 2, rd: 32'hCAFEF00D, err: 1'b0};
        tbl[3] = '{req: 4'b1000, win: 3, lat: 1, rd: 32'h0BADF00D, err: 1'b1};
        tbl[4] = '{req: 4'b1100, win: 2, lat: 7, rd: 32'hA5A5A5A5, err: 1'b0};
        tbl[5] = '{req: 4'b0001, win: 0, lat: 0, rd: 32'h00000001, err: 1'b1};
        for (int t = 0; t < 6; t++) begin
            do_reset();
            randomize_fields();
            step(tbl[t].req, 1'b0, 1'b0, '0, gr, gt, er);
            chk("tbl_grant", grant, onehot(tbl[t].win));
            chk("tbl_valid_next_cycle", bus.out_taskValid, 1'b1);
            for (int l = 0; l < tbl[t].lat; l++) step(tbl[t].req, 1'b0, 1'b0, $urandom, gr, gt, er);
            step(tbl[t].req, 1'b1, tbl[t].err, tbl[t].rd, gr, gt, er);
            chk("tbl_ready", gr, onehot(tbl[t].win));
            chk("tbl_no_timeout", gt, 1'b0);
            chk("tbl_idle_gap", grant, '0);
        end

        // Round robin among 1..3 with continuous requests
        rr_seq[0] = 1; rr_seq[1] = 2; rr_seq[2] = 3; rr_seq[3] = 1;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step(4'b1110, 1'b0, 1'b0, '0, gr, gt, er);
            chk("rr_grant", grant, onehot(rr_seq[k]));
            step(4'b1110, 1'b1, 1'b0, $urandom, gr, gt, er);
            chk("rr_gap", grant, '0);
        end

        // Priority channel arrives mid-transaction: no preemption, pointer untouched by it
        do_reset();
        step(4'b0010, 1'b0, 1'b0, '0, gr, gt, er);
        chk("prio_first", grant, 4'b0010);
        step(4'b0010, 1'b0, 1'b0, '0, gr, gt, er);
        step(4'b1111, 1'b0, 1'b0, '0, gr, gt, er);
        chk("prio_no_preempt", grant, 4'b0010);
        step(4'b1111, 1'b1, 1'b0, 32'h11112222, gr, gt, er);
        chk("prio_ch1_done", gr, 4'b0010);
        step(4'b1101, 1'b0, 1'b0, '0, gr, gt, er);
        chk("prio_ch0_next", grant, 4'b0001);
        step(4'b1101, 1'b1, 1'b0, 32'h33334444, gr, gt, er);
        step(4'b1110, 1'b0, 1'b0, '0, gr, gt, er);
        chk("prio_ptr_kept", grant, 4'b0100);

        // Watchdog abort on the 8th busy cycle
        do_reset();
        step(4'b1100, 1'b0, 1'b0, '0, gr, gt, er);
        chk("to_grant", grant, 4'b0100);
        for (int c = 1; c <= TO; c++) begin
            step(4'b1100, 1'b0, 1'b0, $urandom, gr, gt, er);
            if (c == TO - 1) chk("to_not_early", gt, 1'b0);
        end
        chk("to_ready", gr, 4'b0100);
        chk("to_pulse", gt, 1'b1);
        chk("to_idle", grant, '0);
        step(4'b1000, 1'b0, 1'b0, '0, gr, gt, er);
        chk("to_next_grant", grant, 4'b1000);

        // Asynchronous reset during BUSY, request held across reset
        do_reset();
        step(4'b0010, 1'b0, 1'b0, '0, gr, gt, er);
        step(4'b0010, 1'b0, 1'b0, '0, gr, gt, er);
        chk("arst_pre_valid", bus.out_taskValid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", bus.out_taskValid, 1'b0);
        chk("arst_grant", grant, '0);
        chk("arst_no_ready", bus.in_taskReady, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(4'b0010, 1'b0, 1'b0, '0, gr, gt, er);
        chk("arst_regrant", grant, 4'b0010);

        // Random traffic against the model
        do_reset();
        act = '0;
        hang = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 40 == 0) hang = ($urandom % 4 == 0) ? 1 : 0;
            for (int i = 0; i < N; i++) begin
                if (!act[i] && ($urandom % 4 == 0)) begin
                    act[i]     = 1'b1;
                    ch_addr[i] = $urandom;
                    ch_wdat[i] = $urandom;
                    ch_rw[i]   = 1'($urandom_range(0, 1));
                    ch_wid[i]  = 2'($urandom_range(0, 3));
                end else if (act[i] && ($urandom % 97 == 0)) begin
                    act[i] = 1'b0;
                end
            end
            step(act, (hang == 0) && ($urandom % 3 == 0), ($urandom % 4 == 0), $urandom, gr, gt, er);
            act = act & ~er;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/io_interface_arbiter.md
Name: io_interface_arbiter

Overview:
- Parametrised N-channel arbiter for the CPU IO interface (taskValid/taskReady/taskError handshake with address, rwCtrl, widthCtr, writeBus and readBus).
- Merges CH_NUM requesters onto the single external IO port.
- One channel has absolute priority, used for interrupt-vector fetch by the write-back stage.
- The remaining channels use fixed-priority or round-robin arbitration.
- The grant is held for the whole transaction. A hung transaction is aborted by a timeout watchdog.

Parameters:
- CH_NUM, 4: number of requesting channels, 2..8.
- ADDR_W, 32: address width.
- DATA_W, 32: writeBus/readBus width.
- PRIO_CH, 0: channel index with absolute priority.
- RR_MODE, 1: arbitration among non-priority channels. 0 = fixed priority, lowest index wins. 1 = round robin.
- TIMEOUT, 255: downstream cycles allowed before abort. 0 disables the watchdog.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_taskValid  in  CH_NUM  per-channel request.
- in_address  in  CH_NUM*ADDR_W  per-channel address. Channel i occupies slice [i*ADDR_W +: ADDR_W].
- in_rwCtrl  in  CH_NUM  per-channel read/write control (1 = write).
- in_widthCtr  in  CH_NUM*2  per-channel access width.
- in_writeBus  in  CH_NUM*DATA_W  per-channel write data.
- in_taskReady  out  CH_NUM  per-channel completion.
- in_taskError  out  CH_NUM  per-channel error, valid with in_taskReady.
- in_readBus  out  CH_NUM*DATA_W  per-channel read data.
- out_taskValid  out  1  external request.
- out_address  out  ADDR_W  external address.
- out_rwCtrl  out  1  external read/write control.
- out_widthCtr  out  2  external access width.
- out_writeBus  out  DATA_W  external write data.
- out_taskReady  in  1  external completion.
- out_taskError  in  1  external error.
- out_readBus  in  DATA_W  external read data.
- grant  out  CH_NUM  registered one-hot owner; 0 when idle.
- timeout_err  out  1  one-cycle pulse when the watchdog aborts a transaction.

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE, grant=0, round-robin pointer = 0, watchdog counter = 0.
  - All out_* outputs 0, all in_taskReady/in_taskError/in_readBus 0, timeout_err=0.
  - Reset mid-transaction drops out_taskValid immediately. No completion is reported to the channel.
- Handshake contract:
  - A requester holds taskValid and its request fields stable until it sees taskReady=1.
  - taskReady is a one-cycle pulse. readBus and taskError are valid only in that cycle.
- State IDLE:
  - If any in_taskValid is set, select the winner, register grant, go to BUSY.
  - Selection rule: PRIO_CH wins if requesting. Otherwise fixed priority, or round robin starting at the pointer and skipping PRIO_CH.
  - Latency: request in cycle t drives out_taskValid in cycle t+1.
  - IDLE never asserts out_taskValid.
- State BUSY:
  - out_* request fields are combinationally muxed from the granted channel. out_taskValid = granted in_taskValid.
  - Granted channel receives in_taskReady = out_taskReady, in_taskError = out_taskError, in_readBus = out_readBus, all combinational.
  - Non-granted channels see taskReady=0, taskError=0, readBus=0. They stall; they never receive a spurious completion.
  - Grant cannot be preempted, including by PRIO_CH.
- Completion (out_taskReady=1 in BUSY):
  - Go to IDLE. Clear grant next cycle.
  - Round robin: pointer = granted index + 1, wrapping to 0 past CH_NUM-1. Pointer unchanged when PRIO_CH was served.
  - Minimum gap between back-to-back transactions is one idle cycle.
- Requester withdraws (granted in_taskValid falls with no out_taskReady): abandon the transaction, go to IDLE, report no completion.
- Watchdog:
  - Counter increments each BUSY cycle without out_taskReady.
  - When the counter reaches TIMEOUT, in that cycle: assert granted in_taskReady=1 and in_taskError=1 with readBus=0, force out_taskValid=0, pulse timeout_err, go to IDLE.
  - Counter clears on entering IDLE.
  - out_taskReady arriving in the same cycle as the timeout wins: normal completion, no timeout_err.
- Edge cases:
  - Requests from all channels simultaneously: PRIO_CH is served first, then non-priority channels in pointer order.
  - PRIO_CH out of range 0..CH_NUM-1 is an elaboration error.

Test Plan:
- Channel 2 requests alone, read, downstream ready 3 cycles after out_taskValid with out_readBus=0xDEADBEEF -> out_taskValid rises 1 cycle after request; grant=4'b0100; ch2 sees taskReady=1, readBus=0xDEADBEEF, taskError=0; grant=0 the next cycle.
- RR_MODE=1; channels 1,2,3 request continuously; 1-cycle downstream -> grant sequence 1,2,3,1; each followed by one idle cycle.
- Channel 1 in BUSY, PRIO_CH=0 requests mid-transaction -> ch1 completes; ch0 granted next, ahead of pending ch2/ch3; RR pointer not advanced by ch0.
- TIMEOUT=8; downstream never ready -> on the 8th BUSY cycle granted channel gets taskReady=1/taskError=1, timeout_err pulses, out_taskValid=0; next requester granted afterward.
- rst_n pulled low during BUSY -> out_taskValid=0 and grant=0 asynchronously; after release, a pending request is granted 1 cycle later.
- Downstream returns out_taskError=1 with taskReady -> granted channel sees taskError=1; timeout_err stays 0.
